// File: rtl/req_ack_bcast_responder_pkg.sv
// Shared helpers for the FIFO-based async_operator nodes.
// clog2: ceiling log2, usable in parameter and port width expressions.
package req_ack_bcast_responder_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/bcast_fifo_mem.sv
// Storage, pointers and occupancy for the broadcast responder FIFO.
// Ports:
//   clk, rst      clock; asynchronous active-low reset (pointers and level only)
//   push, wr_data write request and word; ignored while full
//   pop           retire the head word; ignored while empty
//   head          combinational view of the oldest stored word
//   full, empty   occupancy flags derived from the registered level
//   level         number of stored words, 0..depth
module bcast_fifo_mem
  import req_ack_bcast_responder_pkg::*;
#(
  parameter  int data_width = 32,
  parameter  int depth      = 4,
  localparam int ptr_w      = clog2(depth),
  localparam int lvl_w      = clog2(depth) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [data_width-1:0] wr_data,
  input  logic                  pop,
  output logic [data_width-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [lvl_w-1:0]      level
);

  logic [data_width-1:0] mem [depth];
  logic [ptr_w-1:0]      wr_ptr;
  logic [ptr_w-1:0]      rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full  = (level == lvl_w'(depth));
  assign empty = (level == '0);
  assign wr_ok = push & ~full;
  assign rd_ok = pop & ~empty;
  assign head  = mem[rd_ptr];

  // Word storage carries no reset: stale entries are never visible because
  // the level gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Depth is a power of two, so pointers wrap naturally at ptr_w bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/req_ack_bcast_responder.sv
// Responder end of the req/ack pull handshake. Pushed words are buffered and
// each head word is handed once to every requester port; the head retires
// only after all ports have been acked for it.
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   wr_en, wr_data  push strobe and word (dropped when full)
//   full, empty     FIFO occupancy flags
//   level           FIFO occupancy, 0..depth
//   overflow        sticky: a push was attempted while full
//   req             per-port request from the requesters
//   ack             per-port one-cycle acknowledge
//   dout            per-port data, lane i at [data_width*(i+1)-1 : data_width*i]
//   count           number of fully retired words (wraps)
module req_ack_bcast_responder
  import req_ack_bcast_responder_pkg::*;
#(
  parameter  int                    data_width    = 32,
  parameter  int                    depth         = 4,
  parameter  int                    output_size   = 3,
  parameter  logic [data_width-1:0] initial_value = '0,
  localparam int                    lvl_w         = clog2(depth) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [data_width-1:0]             wr_data,
  output logic                              full,
  output logic                              empty,
  output logic [lvl_w-1:0]                  level,
  output logic                              overflow,
  input  logic [output_size-1:0]            req,
  output logic [output_size-1:0]            ack,
  output logic [data_width*output_size-1:0] dout,
  output logic [31:0]                       count
);

  logic [data_width-1:0]  head;
  logic [output_size-1:0] served;
  logic [output_size-1:0] serve_now;
  logic                   retire;

  bcast_fifo_mem #(
    .data_width (data_width),
    .depth      (depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (retire),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // A port still holds req high during its ack cycle, so ~ack blocks a
  // second serve of the same word. The retire may land on the same edge as
  // the last port's serve.
  always_comb begin
    serve_now = req & ~ack & ~served & {output_size{~empty}};
    retire    = ~empty & (&(served | serve_now));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack      <= '0;
      served   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dout     <= {output_size{initial_value}};
    end else begin
      ack <= serve_now;
      if (retire) begin
        served <= '0;
        count  <= count + 32'd1;
      end else begin
        served <= served | serve_now;
      end
      if (wr_en & full) overflow <= 1'b1;
      for (int i = 0; i < output_size; i++) begin
        if (serve_now[i]) dout[i*data_width +: data_width] <= head;
      end
    end
  end

endmodule

// File: tb/tb_req_ack_bcast_responder.sv
module tb_req_ack_bcast_responder;

  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam int          NOUT  = 3;
  localparam logic [31:0] INIT  = 32'hA5A5_0001;
  localparam int          NWORD = 5000;

  logic           clk;
  logic           rst;
  logic           wr_en;
  logic [DW-1:0]  wr_data;
  logic           full;
  logic           empty;
  logic [2:0]     level;
  logic           overflow;
  logic [NOUT-1:0] req;
  logic [NOUT-1:0] ack;
  logic [DW*NOUT-1:0] dout;
  logic [31:0]    count;

  int tests;
  int fails;

  req_ack_bcast_responder #(
    .data_width    (DW),
    .depth         (DEPTH),
    .output_size   (NOUT),
    .initial_value (INIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .req      (req),
    .ack      (ack),
    .dout     (dout),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [31:0] wr_data;
    logic [2:0]  req;
    logic [2:0]  ack;
    logic [2:0]  level;
    logic        full;
    logic        ovf;
    logic [31:0] cnt;
    logic [31:0] lane;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          rx [NOUT];
    int          next_word;
    int          cyc;
    int          acks01;
    logic [31:0] lane;

    tests = 0;
    fails = 0;
    rst = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    req = '0;

    //              wr    data    req     ack     lvl   full  ovf   cnt     lane
    vt[0]  = '{1'b1, 32'd10, 3'b111, 3'b000, 3'd1, 1'b0, 1'b0, 32'd0, INIT};
    vt[1]  = '{1'b1, 32'd11, 3'b111, 3'b111, 3'd1, 1'b0, 1'b0, 32'd1, 32'd10};
    vt[2]  = '{1'b1, 32'd12, 3'b111, 3'b000, 3'd2, 1'b0, 1'b0, 32'd1, 32'd10};
    vt[3]  = '{1'b0, 32'd0,  3'b111, 3'b111, 3'd1, 1'b0, 1'b0, 32'd2, 32'd11};
    vt[4]  = '{1'b0, 32'd0,  3'b111, 3'b000, 3'd1, 1'b0, 1'b0, 32'd2, 32'd11};
    vt[5]  = '{1'b0, 32'd0,  3'b111, 3'b111, 3'd0, 1'b0, 1'b0, 32'd3, 32'd12};
    vt[6]  = '{1'b0, 32'd0,  3'b000, 3'b000, 3'd0, 1'b0, 1'b0, 32'd3, 32'd12};
    vt[7]  = '{1'b1, 32'd1,  3'b000, 3'b000, 3'd1, 1'b0, 1'b0, 32'd3, 32'd12};
    vt[8]  = '{1'b1, 32'd2,  3'b000, 3'b000, 3'd2, 1'b0, 1'b0, 32'd3, 32'd12};
    vt[9]  = '{1'b1, 32'd3,  3'b000, 3'b000, 3'd3, 1'b0, 1'b0, 32'd3, 32'd12};
    vt[10] = '{1'b1, 32'd4,  3'b000, 3'b000, 3'd4, 1'b1, 1'b0, 32'd3, 32'd12};
    vt[11] = '{1'b1, 32'd5,  3'b000, 3'b000, 3'd4, 1'b1, 1'b1, 32'd3, 32'd12};
    vt[12] = '{1'b1, 32'd99, 3'b111, 3'b111, 3'd3, 1'b0, 1'b1, 32'd4, 32'd1};
    vt[13] = '{1'b0, 32'd0,  3'b111, 3'b000, 3'd3, 1'b0, 1'b1, 32'd4, 32'd1};
    vt[14] = '{1'b0, 32'd0,  3'b111, 3'b111, 3'd2, 1'b0, 1'b1, 32'd5, 32'd2};
    vt[15] = '{1'b0, 32'd0,  3'b111, 3'b000, 3'd2, 1'b0, 1'b1, 32'd5, 32'd2};
    vt[16] = '{1'b0, 32'd0,  3'b111, 3'b111, 3'd1, 1'b0, 1'b1, 32'd6, 32'd3};
    vt[17] = '{1'b0, 32'd0,  3'b111, 3'b000, 3'd1, 1'b0, 1'b1, 32'd6, 32'd3};
    vt[18] = '{1'b0, 32'd0,  3'b111, 3'b111, 3'd0, 1'b0, 1'b1, 32'd7, 32'd4};
    vt[19] = '{1'b0, 32'd0,  3'b000, 3'b000, 3'd0, 1'b0, 1'b1, 32'd7, 32'd4};

    // Reset state
    step();
    step();
    chk("reset_ack",   128'(ack), 128'(3'b000));
    chk("reset_level", 128'(level), 128'(3'd0));
    chk("reset_empty", 128'(empty), 128'(1'b1));
    chk("reset_full",  128'(full), 128'(1'b0));
    chk("reset_ovf",   128'(overflow), 128'(1'b0));
    chk("reset_count", 128'(count), 128'(32'd0));
    chk("reset_dout",  128'(dout), 128'({3{INIT}}));
    #2 rst = 1'b1;

    // Broadcast, fill, overflow, full+retire, drain
    for (int k = 0; k < 20; k++) begin
      wr_en   = vt[k].wr_en;
      wr_data = vt[k].wr_data;
      req     = vt[k].req;
      step();
      chk($sformatf("vec%0d_ack", k),   128'(ack), 128'(vt[k].ack));
      chk($sformatf("vec%0d_level", k), 128'(level), 128'(vt[k].level));
      chk($sformatf("vec%0d_empty", k), 128'(empty), 128'(vt[k].level == 3'd0));
      chk($sformatf("vec%0d_full", k),  128'(full), 128'(vt[k].full));
      chk($sformatf("vec%0d_ovf", k),   128'(overflow), 128'(vt[k].ovf));
      chk($sformatf("vec%0d_count", k), 128'(count), 128'(vt[k].cnt));
      chk($sformatf("vec%0d_dout", k),  128'(dout), 128'({3{vt[k].lane}}));
    end

    // Port 2 withholds req: head must stay until it is served
    wr_en = 1'b1; wr_data = 32'd7; req = 3'b011;
    step();
    wr_en = 1'b0;
    chk("p2_push_level", 128'(level), 128'(3'd1));
    step();
    chk("p2_first_ack", 128'(ack), 128'(3'b011));
    chk("p2_lane0", 128'(dout[31:0]), 128'(32'd7));
    chk("p2_lane1", 128'(dout[63:32]), 128'(32'd7));
    acks01 = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ack != 3'b000) acks01++;
      chk($sformatf("p2_wait%0d", c), 128'({level, count}), 128'({3'd1, 32'd7}));
    end
    chk("p2_no_reserve", 128'(acks01), 128'(0));
    req = 3'b111;
    step();
    chk("p2_late_ack", 128'(ack), 128'(3'b100));
    chk("p2_lane2", 128'(dout[95:64]), 128'(32'd7));
    chk("p2_count", 128'(count), 128'(32'd8));
    chk("p2_level", 128'(level), 128'(3'd0));
    req = 3'b000;
    step();

    // Asynchronous reset while an ack is pending
    wr_en = 1'b1; wr_data = 32'd55; req = 3'b001;
    step();
    wr_en = 1'b0;
    step();
    chk("ar_pre_ack", 128'(ack), 128'(3'b001));
    rst = 1'b0;
    #1;
    chk("ar_ack",   128'(ack), 128'(3'b000));
    chk("ar_level", 128'(level), 128'(3'd0));
    chk("ar_count", 128'(count), 128'(32'd0));
    chk("ar_ovf",   128'(overflow), 128'(1'b0));
    chk("ar_dout",  128'(dout), 128'({3{INIT}}));
    req = 3'b000;
    #2 rst = 1'b1;
    step();

    // Long stream against three consumers dropping req 30% of the time
    next_word = 0;
    for (int i = 0; i < NOUT; i++) rx[i] = 0;
    cyc = 0;
    while (cyc < 60000 && !(count == NWORD && rx[0] == NWORD && rx[1] == NWORD && rx[2] == NWORD)) begin
      if (next_word < NWORD && !full) begin
        wr_en = 1'b1;
        wr_data = next_word;
        next_word++;
      end else begin
        wr_en = 1'b0;
      end
      for (int i = 0; i < NOUT; i++) req[i] = ($urandom_range(99) >= 30);
      step();
      cyc++;
      for (int i = 0; i < NOUT; i++) begin
        if (ack[i]) begin
          lane = dout[i*DW +: DW];
          chk($sformatf("stream_p%0d_w%0d", i, rx[i]), 128'(lane), 128'(rx[i]));
          rx[i]++;
        end
      end
    end
    wr_en = 1'b0;
    req = '0;
    chk("stream_done_in_budget", 128'(cyc < 60000), 128'(1'b1));
    chk("stream_p0_total", 128'(rx[0]), 128'(NWORD));
    chk("stream_p1_total", 128'(rx[1]), 128'(NWORD));
    chk("stream_p2_total", 128'(rx[2]), 128'(NWORD));
    chk("stream_count", 128'(count), 128'(NWORD));
    chk("stream_empty", 128'(empty), 128'(1'b1));
    chk("stream_ovf", 128'(overflow), 128'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
